// File: rtl/dab_pkg.sv
// Shared constants, types and helpers for the dual-active-bridge PWM modulator.
package dab_pkg;

  localparam int unsigned ANGLE_W    = 9;
  localparam int unsigned ANGLE_HALF = 256;
  localparam int unsigned N_LEGS     = 4;

  typedef logic [1:0] leg_idx_t;

  // Leg positions inside the gate vectors {B2,A2,B1,A1}
  localparam leg_idx_t LEG_A1 = 2'd0;
  localparam leg_idx_t LEG_B1 = 2'd1;
  localparam leg_idx_t LEG_A2 = 2'd2;
  localparam leg_idx_t LEG_B2 = 2'd3;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef struct packed {
    angle_t tau1;
    angle_t tau2;
    angle_t phi;
  } mod_cmd_t;

  // Zero-state widths cannot be negative; negative requests collapse to 0
  function automatic angle_t clamp_tau(input angle_t t);
    return t[ANGLE_W-1] ? '0 : t;
  endfunction

  // Ideal leg state: high during the first half-period after the leg offset
  function automatic logic in_first_half(input angle_t ph, input angle_t off);
    angle_t d;
    d = ph - off;
    return ~d[ANGLE_W-1];
  endfunction

endpackage

// File: rtl/dab_deadtime_leg.sv
// One bridge leg: registers the ideal state and drives a complementary
// high/low gate pair with a dead-time gap inserted on every transition.
module dab_deadtime_leg
  import dab_pkg::*;
#(
  parameter int unsigned DT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  output logic g_hi,
  output logic g_lo
);

  logic       s_r;
  logic [7:0] cnt;
  logic       changed;

  // A transition of the ideal state restarts the dead-time window
  always_comb begin
    changed = (s != s_r);
  end

  // State register, dead-time counter and registered gate outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r  <= 1'b0;
      cnt  <= '0;
      g_hi <= 1'b0;
      g_lo <= 1'b0;
    end else begin
      s_r <= s;
      if (!en) begin
        cnt  <= '0;
        g_hi <= 1'b0;
        g_lo <= 1'b0;
      end else if (changed) begin
        if (DT == 0) begin
          g_hi <= s;
          g_lo <= ~s;
        end else begin
          cnt  <= 8'd1;
          g_hi <= 1'b0;
          g_lo <= 1'b0;
        end
      end else if (cnt >= 8'(DT)) begin
        g_hi <= s_r;
        g_lo <= ~s_r;
      end else begin
        cnt  <= cnt + 8'd1;
        g_hi <= 1'b0;
        g_lo <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dab_pwm_modulator.sv
// Triple-phase-shift modulator for a dual-active bridge: phase carrier,
// double-buffered modulation commands and four dead-time-protected legs.
module dab_pwm_modulator
  import dab_pkg::*;
#(
  parameter int unsigned DIV = 2,
  parameter int unsigned DT  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      ctrl_valid,
  input  logic signed [ANGLE_W-1:0] tau1,
  input  logic signed [ANGLE_W-1:0] tau2,
  input  logic signed [ANGLE_W-1:0] phi,
  output logic [N_LEGS-1:0]         gate_hi,
  output logic [N_LEGS-1:0]         gate_lo,
  output logic                      period_start,
  output logic                      upd_ack
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]     pre;
  angle_t            ph;
  mod_cmd_t          shadow;
  mod_cmd_t          active;
  mod_cmd_t          cmd_in;
  logic              pending;
  logic              tick;
  logic              wrap;
  logic              upd_now;
  logic [N_LEGS-1:0] s;

  // Input conditioning and carrier/update event decode
  always_comb begin
    cmd_in.tau1 = clamp_tau(tau1);
    cmd_in.tau2 = clamp_tau(tau2);
    cmd_in.phi  = phi;
    tick        = enable && (pre == PW'(DIV - 1));
    wrap        = tick && (ph == '1);
    upd_now     = wrap && (pending || ctrl_valid);
  end

  // Prescaler and phase counter, parked at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      ph  <= '0;
    end else if (!enable) begin
      pre <= '0;
      ph  <= '0;
    end else if (tick) begin
      pre <= '0;
      ph  <= ph + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Shadow capture and period-boundary transfer; a command arriving on the
  // boundary cycle itself bypasses the shadow so it is not lost for a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      upd_ack      <= 1'b0;
    end else begin
      period_start <= wrap;
      upd_ack      <= upd_now;
      if (ctrl_valid) begin
        shadow <= cmd_in;
      end
      if (upd_now) begin
        active  <= ctrl_valid ? cmd_in : shadow;
        pending <= 1'b0;
      end else if (ctrl_valid) begin
        pending <= 1'b1;
      end
    end
  end

  // Ideal leg states from the carrier and the active leg offsets
  always_comb begin
    s         = '0;
    s[LEG_A1] = in_first_half(ph, '0);
    s[LEG_B1] = in_first_half(ph, angle_t'(ANGLE_HALF) + active.tau1);
    s[LEG_A2] = in_first_half(ph, active.phi);
    s[LEG_B2] = in_first_half(ph, active.phi + angle_t'(ANGLE_HALF) + active.tau2);
  end

  for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
    dab_deadtime_leg #(.DT(DT)) u_leg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (enable),
      .s    (s[g]),
      .g_hi (gate_hi[g]),
      .g_lo (gate_lo[g])
    );
  end

endmodule

// File: tb/tb_dab_pwm_modulator.sv
// Scoreboard bench: a cycle-level reference model predicts the gate pattern
// and pulses for each clock edge; a monitor compares them on the falling edge.
module tb_dab_pwm_modulator;

  localparam int unsigned DIV = 1;
  localparam int unsigned DT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              ctrl_valid;
  logic signed [8:0] tau1;
  logic signed [8:0] tau2;
  logic signed [8:0] phi;
  logic [3:0]        gate_hi;
  logic [3:0]        gate_lo;
  logic              period_start;
  logic              upd_ack;

  dab_pwm_modulator #(.DIV(DIV), .DT(DT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ctrl_valid  (ctrl_valid),
    .tau1        (tau1),
    .tau2        (tau2),
    .phi         (phi),
    .gate_hi     (gate_hi),
    .gate_lo     (gate_lo),
    .period_start(period_start),
    .upd_ack     (upd_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
    logic       ps;
    logic       ack;
  } obs_t;

  obs_t exp_q[$];

  // Reference model state: angles held as plain integers 0..511
  int m_ph = 0;
  int m_run = 0;
  int m_edge = 0;
  bit m_en_prev = 0;
  bit m_pend = 0;
  int m_act[3];
  int m_shad[3];
  bit m_sr[4];
  int m_since[4];

  function automatic int clamp_i(input logic signed [8:0] v);
    return (v < 0) ? 0 : int'(v);
  endfunction

  // Reference model: one expected observation per rising edge
  always @(posedge clk) begin
    obs_t e;
    bit   s_new[4];
    int   offs[4];
    bit   wrap;
    int   ph_b;
    e = '0;
    if (!rst_n) begin
      m_ph = 0; m_run = 0; m_en_prev = 0; m_pend = 0;
      for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_shad[i] = 0; end
      for (int l = 0; l < 4; l++) begin m_sr[l] = 0; m_since[l] = 0; end
    end else begin
      ph_b = m_ph;
      offs[0] = 0;
      offs[1] = (256 + m_act[0]) % 512;
      offs[2] = m_act[2];
      offs[3] = (m_act[2] + 256 + m_act[1]) % 512;
      for (int l = 0; l < 4; l++)
        s_new[l] = (((ph_b - offs[l]) % 512 + 512) % 512) < 256;
      m_edge++;
      if (enable) begin
        m_run++;
        wrap = ((m_run % DIV) == 0) && (ph_b == 511);
        m_ph = (m_run / DIV) % 512;
      end else begin
        m_run = 0;
        m_ph  = 0;
        wrap  = 0;
      end
      e.ps = wrap;
      if (wrap && (m_pend || ctrl_valid)) begin
        if (ctrl_valid) begin
          m_act[0] = clamp_i(tau1);
          m_act[1] = clamp_i(tau2);
          m_act[2] = int'(phi) & 511;
        end else begin
          for (int i = 0; i < 3; i++) m_act[i] = m_shad[i];
        end
        m_pend = 0;
        e.ack  = 1;
      end else if (ctrl_valid) begin
        m_shad[0] = clamp_i(tau1);
        m_shad[1] = clamp_i(tau2);
        m_shad[2] = int'(phi) & 511;
        m_pend = 1;
      end
      for (int l = 0; l < 4; l++) begin
        if (enable && (!m_en_prev || (s_new[l] != m_sr[l]))) m_since[l] = m_edge;
        if (enable && (m_edge - m_since[l] >= int'(DT))) begin
          e.hi[l] = s_new[l];
          e.lo[l] = !s_new[l];
        end
        m_sr[l] = s_new[l];
      end
      m_en_prev = enable;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare each presented cycle of outputs against the scoreboard
  always @(negedge clk) begin
    obs_t got;
    obs_t want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {gate_hi, gate_lo, period_start, upd_ack};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got hi=%b lo=%b ps=%b ack=%b expected hi=%b lo=%b ps=%b ack=%b",
                 $time, got.hi, got.lo, got.ps, got.ack, want.hi, want.lo, want.ps, want.ack);
      end
      checks++;
      if ((gate_hi & gate_lo) != 4'b0000) begin
        errors++;
        $display("FAIL shoot_through t=%0t hi=%b lo=%b expected no overlap", $time, gate_hi, gate_lo);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ph(input int target);
    int n = 0;
    while (m_ph != target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_ph != target) begin
      errors++;
      $display("FAIL wait_ph timeout got ph=%0d expected ph=%0d", m_ph, target);
    end
  endtask

  task automatic send(input int t1, input int t2, input int p);
    tau1 = 9'(t1);
    tau2 = 9'(t2);
    phi  = 9'(p);
    ctrl_valid = 1'b1;
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({gate_hi, gate_lo, period_start, upd_ack} !== 10'b0) begin
      errors++;
      $display("FAIL %s got hi=%b lo=%b ps=%b ack=%b expected all 0",
               name, gate_hi, gate_lo, period_start, upd_ack);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ctrl_valid = 1'b0;
    tau1 = '0; tau2 = '0; phi = '0;
    #1 check_zero("reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    run(3);
    enable = 1'b1;
    run(1100);

    // phase shift on the secondary bridge
    wait_ph(10);  send(0, 0, 64);   run(1100);
    // primary zero state, then a clamped negative request
    wait_ph(50);  send(32, 0, 64);  run(1100);
    send(-5, 0, 64);                run(1100);

    // mid-period command, then a newer one on the wrap tick itself
    wait_ph(100); send(0, 16, 128); run(100);
    wait_ph(511); send(20, 30, 200); run(1100);

    // enable dropped mid-period; a command captured while idle is kept
    wait_ph(300); enable = 1'b0;
    run(20); send(10, 10, 300); run(30);
    enable = 1'b1;                  run(1100);

    // asynchronous reset mid-period discards a pending command
    wait_ph(250); send(40, 40, 100);
    wait_ph(300);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    run(1100);

    // randomized commands and enable toggles
    for (int unsigned k = 0; k < 30; k++) begin
      run($urandom_range(0, 700));
      send($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 20));
        enable = 1'b1;
      end
    end
    run(1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dab_pwm_modulator.md
Name: dab_pwm_modulator

Overview:
- Consumes the controller's modulation outputs `tau1`, `tau2` and `phi` (signed 9-bit angles).
- Generates the eight gate signals of the dual-active-bridge, using triple-phase-shift modulation.
- Carrier is a 9-bit phase counter: one period = 512 phase ticks. Commands are double-buffered and applied only at period boundaries.
- Each of the four legs has a complementary high/low gate pair with programmable dead time.

Parameters:
- DIV, 2: clk cycles per phase tick (≥1); switching period = 512*DIV clk cycles.
- DT, 10: dead time in clk cycles (0..255); 0 = no dead time.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  modulator run; low = all gates off.
- ctrl_valid  in  1  one-cycle strobe; tau1/tau2/phi valid.
- tau1  in  9 signed  primary-bridge zero-state width, in ticks.
- tau2  in  9 signed  secondary-bridge zero-state width, in ticks.
- phi  in  9 signed  secondary-to-primary phase shift, in ticks.
- gate_hi  out  4  high-side gates {B2,A2,B1,A1}.
- gate_lo  out  4  low-side gates {B2,A2,B1,A1}.
- period_start  out  1  one-cycle pulse on the cycle the phase counter wraps to 0.
- upd_ack  out  1  one-cycle pulse when the shadow values are copied to active.

Behaviour:
- Reset (async, immediate):
  - gate_hi, gate_lo, period_start and upd_ack = 0.
  - Prescaler = 0, ph = 0.
  - Shadow and active tau1/tau2/phi = 0; pending = 0.
- Prescaler and phase counter:
  - Prescaler counts 0..DIV-1 while enable = 1; the tick fires on the DIV-1 count.
  - ph (9-bit) increments on each tick and wraps 511→0.
- Command capture:
  - On ctrl_valid, tau1/tau2/phi are registered into the shadow set (1-cycle latency) and pending is set.
  - tau values < 0 are clamped to 0 at capture. phi is taken as-is, as a modulo-512 value.
- Command update:
  - Occurs on the tick where ph = 511, and only if pending = 1: shadow → active, pending cleared, upd_ack pulses.
  - If ctrl_valid coincides with that cycle, the new inputs bypass the shadow and go straight to active.
  - Active values never change mid-period.
- Leg offsets (9-bit modulo arithmetic):
  - A1 = 0
  - B1 = 256 + tau1
  - A2 = phi
  - B2 = phi + 256 + tau2
- Ideal leg state: s = ((ph − offset) mod 512) < 256. It is registered once (s_r), one cycle after ph updates.
- Dead time, per leg:
  - When s_r changes, both gates go low for exactly DT clk cycles, starting at that edge.
  - After that, the gate matching s_r goes high (s_r = 1 → gate_hi, s_r = 0 → gate_lo).
  - A further s_r toggle during dead time restarts the count.
  - gate_hi and gate_lo are never both 1.
  - Gates are decoded from registers only: no glitches.
- Enable low:
  - Gates 0 at the next edge; prescaler, ph and dead-time counters are held at 0. Active and shadow values are kept.
  - On enable rising, operation resumes from ph = 0 with all legs in dead time (DT cycles) before the first gate asserts.
- period_start pulses on the tick where ph goes 511→0; it does not pulse while enable = 0.
- Reset mid-period: immediate return to the reset state. Any pending command is lost.

Decomposition:
- Package dab_pkg holds:
  - ANGLE_W = 9, ANGLE_HALF = 256, N_LEGS = 4.
  - Leg index constants LEG_A1, LEG_B1, LEG_A2, LEG_B2.
- Sub-module dab_deadtime_leg (parameter DT):
  - Inputs: clk, rst_n, en, s.
  - Outputs: g_hi, g_lo.
  - Instantiated 4 times.
- Top level holds the prescaler, phase counter, shadow/active registers and offset compare.

Test Plan (DIV=1, DT=4):
- Reset, then enable = 1 with no ctrl_valid → all offsets are 0/256.
  - A1 and A2 are identical; each gate_hi high for 252 cycles per 512-cycle period.
  - period_start has a 512-cycle spacing.
- ctrl_valid with tau1=0, tau2=0, phi=64 → after the next period_start, A2 gate_hi rises 64 cycles after A1 gate_hi; upd_ack is a single pulse.
- ctrl_valid with tau1=32, then tau1=−5 →
  - With 32: the B1 rising edge is 32 cycles later than the complement of A1.
  - With −5: B1 behaves as tau1 = 0.
- ctrl_valid at ph=100 → waveform unchanged until the ph 511→0 wrap.
  - A second ctrl_valid at the exact ph=511 tick cycle → that newer value is used in the next period.
- Every leg transition → exactly 4 cycles with gate_hi = gate_lo = 0; never both 1.
- enable dropped at ph=300, or rst_n pulsed low at ph=300 →
  - enable: gates 0 at the next edge.
  - rst_n: gates 0 immediately; active phi reads back as 0 behaviour.
  - After restart: the first gate_hi on A1 appears 4 cycles after the restart.
